ctrl_decoder: RTL and testbench
===============================

CTRL_DECODER -- requirements
Module: ctrl_decoder

Interface
REQ-001 clk  in  1  system clock; control word registered on falling edge, matching fsm state launched on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 clears all registers immediately.
REQ-003 state  in  8  sequencer state code, `STATE_* symbols from symbols.vh.
REQ-004 opcode  in  8  instruction register; opcode[2:0] = jump condition field.
REQ-005 alu_flags  in  2  {C,Z} from ALU, valid during `STATE_ALU_EXEC.
REQ-006 mar_load, mar_src[1:0]  out  1,2  address-register load; source 00 PC, 01 SP, 10 data bus.
REQ-007 mem_rd, mem_wr  out  1,1  memory read/write strobes.
REQ-008 ir_load, pc_inc, pc_load, pc_src  out  1 each  IR load, PC increment, PC load; pc_src 0 data bus, 1 temp register.
REQ-009 reg_we, reg_src[1:0]  out  1,2  register write; bus source 00 memory, 01 register, 10 ALU, 11 PC.
REQ-010 alu_en, sp_inc, sp_dec  out  1 each  ALU execute, stack-pointer increment/decrement.
REQ-011 halted, err  out  1,1  sticky halt, sticky illegal-state flag.
REQ-012 instr_count  out  16  retired-instruction counter.

Function
REQ-013 All outputs SHALL be registers updated on negedge clk from the state value present; latency half a cycle; no combinational path from inputs to outputs.
REQ-014 Strobes not named for a state SHALL be 0; unnamed source fields SHALL be 00/0.
REQ-015 FETCH_PC: mar_load, mar_src=00. FETCH_INST: mem_rd, ir_load, pc_inc.
REQ-016 MOV_REG: reg_we, reg_src=01. SET_REG: mem_rd, reg_we, reg_src=00; pc_inc additionally only when opcode is `OP_LDI or `OP_CALL.
REQ-017 LOAD_ADDR: mem_rd, mar_load, mar_src=10, pc_inc. SET_MEM: mem_wr, reg_src=01.
REQ-018 ALU_EXEC: alu_en, and flag register {C,Z} SHALL capture alu_flags on that same edge. ALU_OUT: reg_we, reg_src=10.
REQ-019 FETCH_SP: mar_load, mar_src=01. INC_SP: sp_inc. STACK_REG: mem_wr, reg_src=01, sp_dec.
REQ-020 JUMP: mem_rd; if condition true pc_load, pc_src=0, else pc_inc (skip operand). Conditions: 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101-111 never.
REQ-021 Condition SHALL use the flag register value before any update on the same edge.
REQ-022 STORE_PC: mem_wr, reg_src=11, sp_dec. TMP_JUMP: pc_load, pc_src=1. RET: mem_rd, pc_load, pc_src=0.
REQ-023 NEXT: instr_count += 1, wrapping 16'hFFFF -> 0; all strobes 0.
REQ-024 HALT: halted set; once halted, every strobe SHALL stay 0 and instr_count SHALL freeze until reset, regardless of state.
REQ-025 Any state code not in the `STATE_* set SHALL decode to all strobes 0.

Reset
REQ-026 On reset=0 all strobes, source fields, flags, halted, err and instr_count SHALL be 0 asynchronously; first decode occurs on the first falling edge after reset=1.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction; no strobe from the interrupted state SHALL reappear after release.

Configuration
REQ-028 Macro CTRL_DECODER_ILLEGAL_TRAP_EN: when defined, an illegal state code SHALL set err and halted on that edge (sticky until reset); when undefined, err SHALL be constant 0 and illegal codes only follow REQ-025.

Verification
REQ-029 Reset, drive FETCH_PC, FETCH_INST, NEXT -> mar_load/mar_src=00, then mem_rd+ir_load+pc_inc, then instr_count=1.
REQ-030 ALU_EXEC with alu_flags=2'b01, then JUMP with opcode[2:0]=001 -> pc_load=1; repeat with 010 -> pc_inc=1, pc_load=0.
REQ-031 Preload instr_count to 16'hFFFF via 65535 NEXT states, one more NEXT -> instr_count=0.
REQ-032 HALT then FETCH_INST -> halted=1, all strobes 0, instr_count unchanged.
REQ-033 State 8'hFF with CTRL_DECODER_ILLEGAL_TRAP_EN -> err=1, halted=1; without -> err=0, halted=0, strobes 0.
REQ-034 CALL sequence SET_REG, FETCH_SP, STORE_PC, TMP_JUMP with reset pulsed during STORE_PC -> all outputs 0 immediately, no pc_load after release.

Source files
------------

// File: rtl/ctrl_decoder.sv
// Microcoded control-word decoder: turns the sequencer state code into registered strobes on the falling clock edge.
// Optional feature: define CTRL_DECODER_ILLEGAL_TRAP_EN to make an illegal state code set err and halted.
module ctrl_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  state,
  input  logic [7:0]  opcode,
  input  logic [1:0]  alu_flags,
  output logic        mar_load,
  output logic [1:0]  mar_src,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_src,
  output logic        reg_we,
  output logic [1:0]  reg_src,
  output logic        alu_en,
  output logic        sp_inc,
  output logic        sp_dec,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] STATE_FETCH_PC   = 8'h00;
  localparam logic [7:0] STATE_FETCH_INST = 8'h01;
  localparam logic [7:0] STATE_MOV_REG    = 8'h02;
  localparam logic [7:0] STATE_SET_REG    = 8'h03;
  localparam logic [7:0] STATE_LOAD_ADDR  = 8'h04;
  localparam logic [7:0] STATE_SET_MEM    = 8'h05;
  localparam logic [7:0] STATE_ALU_EXEC   = 8'h06;
  localparam logic [7:0] STATE_ALU_OUT    = 8'h07;
  localparam logic [7:0] STATE_FETCH_SP   = 8'h08;
  localparam logic [7:0] STATE_INC_SP     = 8'h09;
  localparam logic [7:0] STATE_STACK_REG  = 8'h0A;
  localparam logic [7:0] STATE_JUMP       = 8'h0B;
  localparam logic [7:0] STATE_STORE_PC   = 8'h0C;
  localparam logic [7:0] STATE_TMP_JUMP   = 8'h0D;
  localparam logic [7:0] STATE_RET        = 8'h0E;
  localparam logic [7:0] STATE_NEXT       = 8'h0F;
  localparam logic [7:0] STATE_HALT       = 8'h10;

  localparam logic [7:0] OP_LDI  = 8'h20;
  localparam logic [7:0] OP_CALL = 8'h48;

  logic             mar_load_d, mar_load_q;
  logic [1:0]       mar_src_d, mar_src_q;
  logic             mem_rd_d, mem_rd_q;
  logic             mem_wr_d, mem_wr_q;
  logic             ir_load_d, ir_load_q;
  logic             pc_inc_d, pc_inc_q;
  logic             pc_load_d, pc_load_q;
  logic             pc_src_d, pc_src_q;
  logic             reg_we_d, reg_we_q;
  logic [1:0]       reg_src_d, reg_src_q;
  logic             alu_en_d, alu_en_q;
  logic             sp_inc_d, sp_inc_q;
  logic             sp_dec_d, sp_dec_q;
  logic             halted_d, halted_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] instr_count_d, instr_count_q;
  logic [1:0]       flags_d, flags_q;
  logic             jump_take_c;

  // Jump condition evaluated on the stored {C,Z}, never on this edge's capture
  always_comb begin
    jump_take_c = 1'b0;
    case (opcode[2:0])
      3'b000:  jump_take_c = 1'b1;
      3'b001:  jump_take_c = flags_q[0];
      3'b010:  jump_take_c = ~flags_q[0];
      3'b011:  jump_take_c = flags_q[1];
      3'b100:  jump_take_c = ~flags_q[1];
      default: jump_take_c = 1'b0;
    endcase
  end

  always_comb begin
    mar_load_d    = 1'b0;
    mar_src_d     = 2'b00;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    ir_load_d     = 1'b0;
    pc_inc_d      = 1'b0;
    pc_load_d     = 1'b0;
    pc_src_d      = 1'b0;
    reg_we_d      = 1'b0;
    reg_src_d     = 2'b00;
    alu_en_d      = 1'b0;
    sp_inc_d      = 1'b0;
    sp_dec_d      = 1'b0;
    halted_d      = halted_q;
    err_d         = err_q;
    instr_count_d = instr_count_q;
    flags_d       = flags_q;

    if (!halted_q) begin
      case (state)
        STATE_FETCH_PC:   mar_load_d = 1'b1;
        STATE_FETCH_INST: begin
          mem_rd_d  = 1'b1;
          ir_load_d = 1'b1;
          pc_inc_d  = 1'b1;
        end
        STATE_MOV_REG: begin
          reg_we_d  = 1'b1;
          reg_src_d = 2'b01;
        end
        STATE_SET_REG: begin
          mem_rd_d = 1'b1;
          reg_we_d = 1'b1;
          pc_inc_d = (opcode == OP_LDI) || (opcode == OP_CALL);
        end
        STATE_LOAD_ADDR: begin
          mem_rd_d   = 1'b1;
          mar_load_d = 1'b1;
          mar_src_d  = 2'b10;
          pc_inc_d   = 1'b1;
        end
        STATE_SET_MEM: begin
          mem_wr_d  = 1'b1;
          reg_src_d = 2'b01;
        end
        STATE_ALU_EXEC: begin
          alu_en_d = 1'b1;
          flags_d  = alu_flags;
        end
        STATE_ALU_OUT: begin
          reg_we_d  = 1'b1;
          reg_src_d = 2'b10;
        end
        STATE_FETCH_SP: begin
          mar_load_d = 1'b1;
          mar_src_d  = 2'b01;
        end
        STATE_INC_SP:     sp_inc_d = 1'b1;
        STATE_STACK_REG: begin
          mem_wr_d  = 1'b1;
          reg_src_d = 2'b01;
          sp_dec_d  = 1'b1;
        end
        STATE_JUMP: begin
          mem_rd_d  = 1'b1;
          pc_load_d = jump_take_c;
          pc_inc_d  = ~jump_take_c;
        end
        STATE_STORE_PC: begin
          mem_wr_d  = 1'b1;
          reg_src_d = 2'b11;
          sp_dec_d  = 1'b1;
        end
        STATE_TMP_JUMP: begin
          pc_load_d = 1'b1;
          pc_src_d  = 1'b1;
        end
        STATE_RET: begin
          mem_rd_d  = 1'b1;
          pc_load_d = 1'b1;
        end
        STATE_NEXT:       instr_count_d = instr_count_q + CNT_W'(1);
        STATE_HALT:       halted_d = 1'b1;
        default: begin
`ifdef CTRL_DECODER_ILLEGAL_TRAP_EN
          err_d    = 1'b1;
          halted_d = 1'b1;
`else
          err_d    = 1'b0;
`endif
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mar_load_q    <= 1'b0;
      mar_src_q     <= 2'b00;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      ir_load_q     <= 1'b0;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_src_q      <= 1'b0;
      reg_we_q      <= 1'b0;
      reg_src_q     <= 2'b00;
      alu_en_q      <= 1'b0;
      sp_inc_q      <= 1'b0;
      sp_dec_q      <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
      instr_count_q <= '0;
      flags_q       <= 2'b00;
    end else begin
      mar_load_q    <= mar_load_d;
      mar_src_q     <= mar_src_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      ir_load_q     <= ir_load_d;
      pc_inc_q      <= pc_inc_d;
      pc_load_q     <= pc_load_d;
      pc_src_q      <= pc_src_d;
      reg_we_q      <= reg_we_d;
      reg_src_q     <= reg_src_d;
      alu_en_q      <= alu_en_d;
      sp_inc_q      <= sp_inc_d;
      sp_dec_q      <= sp_dec_d;
      halted_q      <= halted_d;
      err_q         <= err_d;
      instr_count_q <= instr_count_d;
      flags_q       <= flags_d;
    end
  end

  assign mar_load    = mar_load_q;
  assign mar_src     = mar_src_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign ir_load     = ir_load_q;
  assign pc_inc      = pc_inc_q;
  assign pc_load     = pc_load_q;
  assign pc_src      = pc_src_q;
  assign reg_we      = reg_we_q;
  assign reg_src     = reg_src_q;
  assign alu_en      = alu_en_q;
  assign sp_inc      = sp_inc_q;
  assign sp_dec      = sp_dec_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_ctrl_decoder.sv
// Bench for ctrl_decoder: directed vector table, reset/CALL and counter-wrap sequences, random stimulus vs. a table-based model.
module tb_ctrl_decoder;

  localparam logic [7:0] S_FETCH_PC   = 8'h00;
  localparam logic [7:0] S_FETCH_INST = 8'h01;
  localparam logic [7:0] S_MOV_REG    = 8'h02;
  localparam logic [7:0] S_SET_REG    = 8'h03;
  localparam logic [7:0] S_LOAD_ADDR  = 8'h04;
  localparam logic [7:0] S_SET_MEM    = 8'h05;
  localparam logic [7:0] S_ALU_EXEC   = 8'h06;
  localparam logic [7:0] S_ALU_OUT    = 8'h07;
  localparam logic [7:0] S_FETCH_SP   = 8'h08;
  localparam logic [7:0] S_INC_SP     = 8'h09;
  localparam logic [7:0] S_STACK_REG  = 8'h0A;
  localparam logic [7:0] S_JUMP       = 8'h0B;
  localparam logic [7:0] S_STORE_PC   = 8'h0C;
  localparam logic [7:0] S_TMP_JUMP   = 8'h0D;
  localparam logic [7:0] S_RET        = 8'h0E;
  localparam logic [7:0] S_NEXT       = 8'h0F;
  localparam logic [7:0] S_HALT       = 8'h10;
  localparam logic [7:0] OP_LDI       = 8'h20;
  localparam logic [7:0] OP_CALL      = 8'h48;

  typedef struct packed {
    logic        mar_load;
    logic [1:0]  mar_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        ir_load;
    logic        pc_inc;
    logic        pc_load;
    logic        pc_src;
    logic        reg_we;
    logic [1:0]  reg_src;
    logic        alu_en;
    logic        sp_inc;
    logic        sp_dec;
    logic        halted;
    logic        err;
    logic [15:0] instr_count;
  } out_t;

  typedef struct {
    string      name;
    logic [7:0] st;
    logic [7:0] op;
    logic [1:0] fl;
    out_t       exp;
  } vec_t;

  logic        clk, reset;
  logic [7:0]  state, opcode;
  logic [1:0]  alu_flags;
  logic        mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load, pc_src, reg_we;
  logic        alu_en, sp_inc, sp_dec, halted, err;
  logic [1:0]  mar_src, reg_src;
  logic [15:0] instr_count;

  int checks = 0;
  int failures = 0;

  ctrl_decoder dut (
    .clk(clk), .reset(reset), .state(state), .opcode(opcode), .alu_flags(alu_flags),
    .mar_load(mar_load), .mar_src(mar_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .pc_src(pc_src),
    .reg_we(reg_we), .reg_src(reg_src), .alu_en(alu_en), .sp_inc(sp_inc),
    .sp_dec(sp_dec), .halted(halted), .err(err), .instr_count(instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: stored flags {C,Z}, sticky bits, retired count
  out_t       base_tab [logic [7:0]];
  logic [1:0] m_flags;
  logic       m_halt, m_err;
  int         m_cnt;

  function automatic out_t sample();
    out_t a;
    a.mar_load = mar_load;  a.mar_src = mar_src;  a.mem_rd = mem_rd;   a.mem_wr = mem_wr;
    a.ir_load = ir_load;    a.pc_inc = pc_inc;    a.pc_load = pc_load; a.pc_src = pc_src;
    a.reg_we = reg_we;      a.reg_src = reg_src;  a.alu_en = alu_en;   a.sp_inc = sp_inc;
    a.sp_dec = sp_dec;      a.halted = halted;    a.err = err;         a.instr_count = instr_count;
    return a;
  endfunction

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%09h exp=%09h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [7:0] s, input logic [7:0] op, input logic [1:0] f);
    @(posedge clk);
    #1;
    state = s; opcode = op; alu_flags = f;
    @(negedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, held across one falling edge
  task automatic do_reset(input logic [7:0] hold_state);
    #2 reset = 1'b0;
    state = hold_state;
    #1 check("reset_async", '0);
    @(negedge clk);
    #1 check("reset_hold", '0);
    reset = 1'b1;
    m_flags = 2'b00; m_halt = 1'b0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic out_t model_step(input logic [7:0] s, input logic [7:0] op, input logic [1:0] f);
    out_t e;
    bit   z, c, take;
    e = '0;
    if (!m_halt) begin
      if (!base_tab.exists(s)) begin
`ifdef CTRL_DECODER_ILLEGAL_TRAP_EN
        m_err = 1'b1;
        m_halt = 1'b1;
`endif
      end else begin
        e = base_tab[s];
        if (s == S_SET_REG && (op == OP_LDI || op == OP_CALL)) e.pc_inc = 1'b1;
        if (s == S_JUMP) begin
          z = m_flags[0];
          c = m_flags[1];
          take = (op[2:0] == 3'd0) || (op[2:0] == 3'd1 && z) || (op[2:0] == 3'd2 && !z) ||
                 (op[2:0] == 3'd3 && c) || (op[2:0] == 3'd4 && !c);
          if (take) e.pc_load = 1'b1;
          else      e.pc_inc  = 1'b1;
        end
        if (s == S_ALU_EXEC) m_flags = f;
        if (s == S_NEXT)     m_cnt = (m_cnt + 1) % 65536;
        if (s == S_HALT)     m_halt = 1'b1;
      end
    end
    e.halted = m_halt;
    e.err = m_err;
    e.instr_count = 16'(m_cnt);
    return e;
  endfunction

  vec_t vecs[$];
  out_t exp_o;

  initial begin
    reset = 1'b0;
    state = S_FETCH_PC; opcode = 8'h00; alu_flags = 2'b00;
    m_flags = 2'b00; m_halt = 1'b0; m_err = 1'b0; m_cnt = 0;

    base_tab[S_FETCH_PC]   = out_t'{mar_load:1'b1, default:'0};
    base_tab[S_FETCH_INST] = out_t'{mem_rd:1'b1, ir_load:1'b1, pc_inc:1'b1, default:'0};
    base_tab[S_MOV_REG]    = out_t'{reg_we:1'b1, reg_src:2'b01, default:'0};
    base_tab[S_SET_REG]    = out_t'{mem_rd:1'b1, reg_we:1'b1, default:'0};
    base_tab[S_LOAD_ADDR]  = out_t'{mem_rd:1'b1, mar_load:1'b1, mar_src:2'b10, pc_inc:1'b1, default:'0};
    base_tab[S_SET_MEM]    = out_t'{mem_wr:1'b1, reg_src:2'b01, default:'0};
    base_tab[S_ALU_EXEC]   = out_t'{alu_en:1'b1, default:'0};
    base_tab[S_ALU_OUT]    = out_t'{reg_we:1'b1, reg_src:2'b10, default:'0};
    base_tab[S_FETCH_SP]   = out_t'{mar_load:1'b1, mar_src:2'b01, default:'0};
    base_tab[S_INC_SP]     = out_t'{sp_inc:1'b1, default:'0};
    base_tab[S_STACK_REG]  = out_t'{mem_wr:1'b1, reg_src:2'b01, sp_dec:1'b1, default:'0};
    base_tab[S_JUMP]       = out_t'{mem_rd:1'b1, default:'0};
    base_tab[S_STORE_PC]   = out_t'{mem_wr:1'b1, reg_src:2'b11, sp_dec:1'b1, default:'0};
    base_tab[S_TMP_JUMP]   = out_t'{pc_load:1'b1, pc_src:1'b1, default:'0};
    base_tab[S_RET]        = out_t'{mem_rd:1'b1, pc_load:1'b1, default:'0};
    base_tab[S_NEXT]       = out_t'{default:'0};
    base_tab[S_HALT]       = out_t'{default:'0};

    vecs.push_back('{"fetch_pc",    S_FETCH_PC,   8'h00, 2'b00, out_t'{mar_load:1'b1, default:'0}});
    vecs.push_back('{"fetch_inst",  S_FETCH_INST, 8'h00, 2'b00, out_t'{mem_rd:1'b1, ir_load:1'b1, pc_inc:1'b1, default:'0}});
    vecs.push_back('{"next_1",      S_NEXT,       8'h00, 2'b00, out_t'{instr_count:16'd1, default:'0}});
    vecs.push_back('{"alu_z",       S_ALU_EXEC,   8'h00, 2'b01, out_t'{alu_en:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"jump_z",      S_JUMP,       8'h01, 2'b00, out_t'{mem_rd:1'b1, pc_load:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"jump_nz",     S_JUMP,       8'h02, 2'b00, out_t'{mem_rd:1'b1, pc_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"set_reg_ldi", S_SET_REG,    OP_LDI, 2'b00, out_t'{mem_rd:1'b1, reg_we:1'b1, pc_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"set_reg_oth", S_SET_REG,    8'h07, 2'b00, out_t'{mem_rd:1'b1, reg_we:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"load_addr",   S_LOAD_ADDR,  8'h00, 2'b00, out_t'{mem_rd:1'b1, mar_load:1'b1, mar_src:2'b10, pc_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"set_mem",     S_SET_MEM,    8'h00, 2'b00, out_t'{mem_wr:1'b1, reg_src:2'b01, instr_count:16'd1, default:'0}});
    vecs.push_back('{"alu_c",       S_ALU_EXEC,   8'h00, 2'b10, out_t'{alu_en:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"jump_c",      S_JUMP,       8'h03, 2'b00, out_t'{mem_rd:1'b1, pc_load:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"jump_nc",     S_JUMP,       8'h0C, 2'b00, out_t'{mem_rd:1'b1, pc_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"jump_never",  S_JUMP,       8'h07, 2'b00, out_t'{mem_rd:1'b1, pc_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"fetch_sp",    S_FETCH_SP,   8'h00, 2'b00, out_t'{mar_load:1'b1, mar_src:2'b01, instr_count:16'd1, default:'0}});
    vecs.push_back('{"inc_sp",      S_INC_SP,     8'h00, 2'b00, out_t'{sp_inc:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"stack_reg",   S_STACK_REG,  8'h00, 2'b00, out_t'{mem_wr:1'b1, reg_src:2'b01, sp_dec:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"store_pc",    S_STORE_PC,   8'h00, 2'b00, out_t'{mem_wr:1'b1, reg_src:2'b11, sp_dec:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"tmp_jump",    S_TMP_JUMP,   8'h00, 2'b00, out_t'{pc_load:1'b1, pc_src:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"ret",         S_RET,        8'h00, 2'b00, out_t'{mem_rd:1'b1, pc_load:1'b1, instr_count:16'd1, default:'0}});
    vecs.push_back('{"mov_reg",     S_MOV_REG,    8'h00, 2'b00, out_t'{reg_we:1'b1, reg_src:2'b01, instr_count:16'd1, default:'0}});
    vecs.push_back('{"alu_out",     S_ALU_OUT,    8'h00, 2'b00, out_t'{reg_we:1'b1, reg_src:2'b10, instr_count:16'd1, default:'0}});
    vecs.push_back('{"next_2",      S_NEXT,       8'h00, 2'b00, out_t'{instr_count:16'd2, default:'0}});
    vecs.push_back('{"jump_always", S_JUMP,       8'hF8, 2'b00, out_t'{mem_rd:1'b1, pc_load:1'b1, instr_count:16'd2, default:'0}});
    vecs.push_back('{"next_3",      S_NEXT,       8'h00, 2'b00, out_t'{instr_count:16'd3, default:'0}});
    vecs.push_back('{"halt",        S_HALT,       8'h00, 2'b00, out_t'{halted:1'b1, instr_count:16'd3, default:'0}});
    vecs.push_back('{"halted_fi",   S_FETCH_INST, 8'h00, 2'b00, out_t'{halted:1'b1, instr_count:16'd3, default:'0}});
    vecs.push_back('{"halted_next", S_NEXT,       8'h00, 2'b00, out_t'{halted:1'b1, instr_count:16'd3, default:'0}});

    // Power-on reset
    @(negedge clk);
    #1 check("por", '0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].op, vecs[i].fl);
      check(vecs[i].name, vecs[i].exp);
    end

    // Illegal state code
    do_reset(S_FETCH_PC);
    step(8'hFF, 8'h00, 2'b00);
`ifdef CTRL_DECODER_ILLEGAL_TRAP_EN
    check("illegal_ff", out_t'{err:1'b1, halted:1'b1, default:'0});
    step(S_FETCH_PC, 8'h00, 2'b00);
    check("illegal_sticky", out_t'{err:1'b1, halted:1'b1, default:'0});
`else
    check("illegal_ff", '0);
    step(S_FETCH_PC, 8'h00, 2'b00);
    check("illegal_recover", out_t'{mar_load:1'b1, default:'0});
`endif

    // CALL sequence abandoned by reset during STORE_PC
    do_reset(S_FETCH_PC);
    step(S_SET_REG, OP_CALL, 2'b00);
    check("call_set_reg", out_t'{mem_rd:1'b1, reg_we:1'b1, pc_inc:1'b1, default:'0});
    step(S_FETCH_SP, OP_CALL, 2'b00);
    check("call_fetch_sp", out_t'{mar_load:1'b1, mar_src:2'b01, default:'0});
    step(S_STORE_PC, OP_CALL, 2'b00);
    check("call_store_pc", out_t'{mem_wr:1'b1, reg_src:2'b11, sp_dec:1'b1, default:'0});
    do_reset(S_TMP_JUMP);
    step(S_FETCH_PC, 8'h00, 2'b00);
    check("call_after_rst", out_t'{mar_load:1'b1, default:'0});

    // Randomized run against the model
    do_reset(S_FETCH_PC);
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] s, op;
      logic [1:0] f;
      int         r;
      r = $urandom_range(0, 19);
      s = (r <= 16) ? 8'(r) : 8'(8'h11 + $urandom_range(0, 8'hEE));
      op = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? OP_LDI : OP_CALL) : 8'($urandom);
      f = 2'($urandom);
      step(s, op, f);
      exp_o = model_step(s, op, f);
      check("random", exp_o);
      if ($urandom_range(0, 39) == 0) do_reset(8'($urandom));
    end

    // Retired-instruction counter wrap
    do_reset(S_FETCH_PC);
    for (int n = 0; n < 65535; n++) step(S_NEXT, 8'h00, 2'b00);
    check("cnt_ffff", out_t'{instr_count:16'hFFFF, default:'0});
    step(S_NEXT, 8'h00, 2'b00);
    check("cnt_wrap", '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
